// File: rtl/div.sv
// Iterative 64/32-bit integer divider with restoring division, one quotient bit per cycle.
// Handles the signed and unsigned forms, plus the divide-by-zero and signed-overflow shortcuts.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        div_signed,
  input  logic        alu_32,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_q,
  output logic [63:0] out_r
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        w32_q, w32_d;
  logic [63:0] res_q_q, res_q_d;
  logic [63:0] res_r_q, res_r_d;

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] fmt(input logic [63:0] v, input logic w);
    return w ? sext32(v) : v;
  endfunction

  // Operands extended to 64 bits at the requested width and signedness
  logic [63:0] a_ext, b_ext, a_mag, b_mag, a_min;
  logic        a_neg, b_neg, b_zero, ovf;

  always_comb begin
    a_ext = in_a;
    b_ext = in_b;
    if (alu_32) begin
      a_ext = div_signed ? sext32(in_a) : {32'd0, in_a[31:0]};
      b_ext = div_signed ? sext32(in_b) : {32'd0, in_b[31:0]};
    end
    a_neg  = div_signed & a_ext[63];
    b_neg  = div_signed & b_ext[63];
    a_mag  = a_neg ? (~a_ext + 64'd1) : a_ext;
    b_mag  = b_neg ? (~b_ext + 64'd1) : b_ext;
    a_min  = alu_32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    b_zero = (b_ext == 64'd0);
    ovf    = div_signed & (a_ext == a_min) & (b_ext == {64{1'b1}});
  end

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  // The partial remainder is always below the divisor, so bit 64 of the 65-bit
  // difference is a reliable borrow flag.
  logic [64:0] trial, diff;
  logic        fits, last;
  logic [63:0] rem_nx, quo_nx, q_fix, r_fix;

  always_comb begin
    trial  = {rem_q, quo_q[63]};
    diff   = trial + ~{1'b0, dvs_q} + 65'd1;
    fits   = ~diff[64];
    rem_nx = fits ? diff[63:0] : trial[63:0];
    quo_nx = {quo_q[62:0], fits};
    q_fix  = fmt(qneg_q ? (~quo_nx + 64'd1) : quo_nx, w32_q);
    r_fix  = fmt(rneg_q ? (~rem_nx + 64'd1) : rem_nx, w32_q);
    last   = (cnt_q == (w32_q ? 7'd31 : 7'd63));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    w32_d   = w32_q;
    res_q_d = res_q_q;
    res_r_d = res_r_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d  = 7'd0;
          w32_d  = alu_32;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dvs_d  = b_mag;
          rem_d  = 64'd0;
          // Word operands sit in the top half so the MSB-first scan sees them directly
          quo_d  = alu_32 ? {a_mag[31:0], 32'd0} : a_mag;
          if (b_zero) begin
            res_q_d = {64{1'b1}};
            res_r_d = fmt(a_ext, alu_32);
            state_d = DONE;
          end else if (ovf) begin
            res_q_d = a_ext;
            res_r_d = 64'd0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 7'd1;
        if (last) begin
          res_q_d = q_fix;
          res_r_d = r_fix;
          cnt_d   = 7'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 7'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      rem_q   <= 64'd0;
      quo_q   <= 64'd0;
      dvs_q   <= 64'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      w32_q   <= 1'b0;
      res_q_q <= 64'd0;
      res_r_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      w32_q   <= w32_d;
      res_q_q <= res_q_d;
      res_r_q <= res_r_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_q     = res_q_q;
  assign out_r     = res_r_q;

endmodule

// File: tb/tb_div.sv
// Bench for div: directed scenarios plus randomized operations against an arithmetic model.
module tb_div;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = 64'd0;
  logic [63:0] in_b = 64'd0;
  logic        div_signed = 1'b0;
  logic        alu_32 = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_q;
  logic [63:0] out_r;

  int checks = 0;
  int errors = 0;

  div dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_signed(div_signed), .alu_32(alu_32),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic plus the two special-case rules
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                input logic w, output logic [63:0] q, output logic [63:0] r,
                                output int lat);
    logic [31:0] a32, b32, q32, r32;
    int          sa, sb;
    longint      la, lb;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      lat = 32;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; lat = 1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; lat = 1;
      end else if (s) begin
        sa = a32; sb = b32;
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      lat = 64;
      if (b == 64'd0) begin
        q = {64{1'b1}}; r = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
        q = a; r = 64'd0; lat = 1;
      end else if (s) begin
        la = a; lb = b;
        q = la / lb; r = la % lb;
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    in_a = a; in_b = b; div_signed = s; alu_32 = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, ".ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic w);
    logic [63:0] eq, er;
    int          elat, lat;
    model(a, b, s, w, eq, er, elat);
    accept(a, b, s, w);
    wait_valid(lat);
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    check({tag, ".q"}, out_q, eq);
    check({tag, ".r"}, out_r, er);
    check({tag, ".busy"}, {63'd0, in_ready}, 64'd0);
    $display("op %s a=%h b=%h s=%0d w=%0d q=%h r=%h lat=%0d", tag, a, b, s, w, out_q, out_r, lat);
    if (!out_valid) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    handoff(tag);
  endtask

  initial begin
    logic [63:0] ra, rb, eq, er;
    logic        rs, rw, seen;
    int          elat, lat;

    #22;
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.out_q", out_q, 64'd0);
    check("rst.out_r", out_r, 64'd0);
    rst = 1'b0;

    // Accepted on the very first edge after reset release
    run_op("u64_100_7", 64'd100, 64'd7, 1'b0, 1'b0);
    run_op("s64_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0);
    run_op("div0", 64'h1234, 64'd0, 1'b0, 1'b0);
    run_op("s64_ovf", 64'h8000_0000_0000_0000, {64{1'b1}}, 1'b1, 1'b0);
    run_op("w_ovf", 64'hDEAD_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1);
    run_op("wu_ff_1", 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1);
    run_op("w_div0", 64'h5555_0000_9000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1);
    run_op("s64_min_1", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = 64'd0;
        1: rb = {64{1'b1}};
        2: rb = 64'($urandom_range(1, 20));
        3: begin
          ra = rw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          rb = {$urandom, 32'hFFFF_FFFF};
          if (!rw) rb = {64{1'b1}};
        end
        default: rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      run_op($sformatf("rand%0d", i), ra, rb, rs, rw);
    end

    // Backpressure: result held while the consumer stalls
    model(64'd1000, 64'd33, 1'b0, 1'b0, eq, er, elat);
    accept(64'd1000, 64'd33, 1'b0, 1'b0);
    wait_valid(lat);
    check("bp.latency", 64'(lat), 64'(elat));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp.valid", {63'd0, out_valid}, 64'd1);
      check("bp.q", out_q, eq);
      check("bp.r", out_r, er);
      check("bp.in_ready", {63'd0, in_ready}, 64'd0);
    end
    $display("op bp q=%h r=%h", out_q, out_r);
    handoff("bp");

    // Flush at iteration 20
    accept(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc.valid", {63'd0, out_valid}, 64'd0);
    check("flush_calc.idle", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_calc.no_result", {63'd0, seen}, 64'd0);
    $display("op flush_calc done");

    // Flush wins over a simultaneous request
    in_a = 64'd100; in_b = 64'd7; div_signed = 1'b0; alu_32 = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_acc.idle", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_acc.no_result", {63'd0, seen}, 64'd0);
    $display("op flush_accept done");

    // Flush wins over handoff in DONE
    accept(64'd9, 64'd0, 1'b0, 1'b0);
    wait_valid(lat);
    check("flush_done.latency", 64'(lat), 64'd1);
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    flush = 1'b0;
    check("flush_done.valid", {63'd0, out_valid}, 64'd0);
    check("flush_done.idle", {63'd0, in_ready}, 64'd1);
    $display("op flush_done done");

    // Reset pulse while a result is held
    accept(64'd100, 64'd7, 1'b0, 1'b0);
    wait_valid(lat);
    check("rst_done.latency", 64'(lat), 64'd64);
    #2;
    rst = 1'b1;
    #1;
    check("rst_done.valid", {63'd0, out_valid}, 64'd0);
    check("rst_done.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_done.q", out_q, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_done.no_result", {63'd0, seen}, 64'd0);
    $display("op rst_done done");
    run_op("after_rst", 64'd100, 64'd7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
